ahb_burst_master: RTL and testbench

AHB-lite master-side burst sequencer that drives the memory slave over the shared AHB-lite bus. It accepts one transfer command at a time (start address, direction, burst type, length) and issues the address/control phases with correct HTRANS sequencing and INCR/WRAP address generation. Address and data phases are pipelined. It honours Hready wait states and aborts the burst on an error response. It moves write data from an upstream source and returns read data to it.

---
 rtl/ahb_burst_master_if.sv | 29 ++
 rtl/ahb_burst_master.sv | 235 +++++++++++++++++++++++
 tb/tb_ahb_burst_master.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_burst_master_if.sv
// AHB-lite bus between the burst master and the memory slave.
// The master drives address/control/write data; the slave returns Hready, Hresp and Hrdata.
interface ahb_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              Hsel;
    logic [ADDR_W-1:0] Haddr;
    logic              Hwrite;
    logic [2:0]        Hsize;
    logic [2:0]        Hburst;
    logic [3:0]        Hprot;
    logic              Hmastlock;
    logic [1:0]        Htrans;
    logic [DATA_W-1:0] Hwdata;
    logic              Hready;
    logic              Hresp;
    logic [DATA_W-1:0] Hrdata;

    modport master (
        output Hsel, Haddr, Hwrite, Hsize, Hburst, Hprot, Hmastlock, Htrans, Hwdata,
        input  Hready, Hresp, Hrdata
    );

    modport slave (
        input  Hsel, Haddr, Hwrite, Hsize, Hburst, Hprot, Hmastlock, Htrans, Hwdata,
        output Hready, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-lite burst sequencer: takes one command at a time and issues a pipelined
// NONSEQ/SEQ burst with INCR/WRAP address stepping, wait states and error abort.
module ahb_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [3:0]        cmd_len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_pop,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state,
    ahb_burst_master_if.master bus
);

    // Handshake: a command transfers on the rising edge where cmd_valid and
    // cmd_ready are both high. cmd_ready is high only in IDLE (and never in
    // reset); wdata_pop/rdata_valid/done are single-cycle pulses with no back-pressure.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_BURST = 3'd2,
        S_LAST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t state, state_next;

    logic              accept;
    logic              step;
    logic              finish_addr;
    logic              abort;
    logic              pop_c;

    logic [3:0]        beats_m1;
    logic              wrap_c;

    logic [ADDR_W-1:0] haddr_q;
    logic [1:0]        htrans_q;
    logic              hsel_q;
    logic              hwrite_q;
    logic [2:0]        hburst_q;
    logic [DATA_W-1:0] hwdata_q;
    logic [DATA_W-1:0] wbuf_q;
    logic [3:0]        beats_left_q;
    logic [ADDR_W-1:0] mask_q;
    logic              dphase_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q;

    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] next_addr;

    // Beat count minus one; WRAP bursts also set the wrap flag.
    always_comb begin
        beats_m1 = 4'd0;
        wrap_c   = 1'b0;
        case (cmd_burst)
            3'b000:  beats_m1 = 4'd0;
            3'b001:  beats_m1 = cmd_len;
            3'b010:  begin beats_m1 = 4'd3;  wrap_c = 1'b1; end
            3'b011:  beats_m1 = 4'd3;
            3'b100:  begin beats_m1 = 4'd7;  wrap_c = 1'b1; end
            3'b101:  beats_m1 = 4'd7;
            3'b110:  begin beats_m1 = 4'd15; wrap_c = 1'b1; end
            default: beats_m1 = 4'd15;
        endcase
    end

    // An all-ones mask turns the wrap formula into a plain increment, so INCR
    // and WRAP share one stepping path. For WRAPn the mask is 4n-1.
    assign addr_inc  = haddr_q + {{(ADDR_W-3){1'b0}}, 3'b100};
    assign next_addr = (haddr_q & ~mask_q) | (addr_inc & mask_q);

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        step        = 1'b0;
        finish_addr = 1'b0;
        abort       = 1'b0;
        pop_c       = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    pop_c      = cmd_write;
                    state_next = S_ADDR;
                end
            end
            S_ADDR, S_BURST: begin
                if (dphase_q && bus.Hresp) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end else if (bus.Hready) begin
                    if (beats_left_q != 4'd0) begin
                        step       = 1'b1;
                        pop_c      = hwrite_q;
                        state_next = S_BURST;
                    end else begin
                        finish_addr = 1'b1;
                        state_next  = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (dphase_q && bus.Hresp) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end else if (bus.Hready) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            haddr_q       <= '0;
            htrans_q      <= TR_IDLE;
            hsel_q        <= 1'b0;
            hwrite_q      <= 1'b0;
            hburst_q      <= 3'b000;
            hwdata_q      <= '0;
            wbuf_q        <= '0;
            beats_left_q  <= 4'd0;
            mask_q        <= '1;
            dphase_q      <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;

            if (accept) begin
                haddr_q      <= cmd_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
                htrans_q     <= TR_NONSEQ;
                hsel_q       <= 1'b1;
                hwrite_q     <= cmd_write;
                hburst_q     <= cmd_burst;
                beats_left_q <= beats_m1;
                mask_q       <= wrap_c ? {{(ADDR_W-6){1'b0}}, beats_m1, 2'b11} : '1;
                err_q        <= 1'b0;
                if (cmd_write) begin
                    wbuf_q <= wdata;
                end
            end

            if (abort) begin
                htrans_q <= TR_IDLE;
                hsel_q   <= 1'b0;
                err_q    <= 1'b1;
                dphase_q <= 1'b0;
            end else begin
                // Hready ends the current data phase and the current address
                // phase together; an active address phase becomes the next data phase.
                if (bus.Hready) begin
                    dphase_q <= htrans_q[1];
                end

                if (dphase_q && bus.Hready && !hwrite_q) begin
                    rdata_q       <= bus.Hrdata;
                    rdata_valid_q <= 1'b1;
                end

                if (step) begin
                    haddr_q      <= next_addr;
                    htrans_q     <= TR_SEQ;
                    beats_left_q <= beats_left_q - 4'd1;
                end

                if (finish_addr) begin
                    htrans_q <= TR_IDLE;
                    hsel_q   <= 1'b0;
                end

                // The buffered beat moves onto Hwdata as its address phase
                // completes, and the buffer refills only if another beat follows.
                if ((step || finish_addr) && hwrite_q) begin
                    hwdata_q <= wbuf_q;
                end
                if (step && hwrite_q) begin
                    wbuf_q <= wdata;
                end
            end
        end
    end

    assign cmd_ready   = (state == S_IDLE) && !Hreset;
    assign wdata_pop   = pop_c && !Hreset;
    assign done        = (state == S_DONE) && !Hreset;
    assign err         = done && err_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign dbg_state   = state;

    assign bus.Hsel      = hsel_q;
    assign bus.Haddr     = haddr_q;
    assign bus.Hwrite    = hwrite_q;
    assign bus.Hsize     = 3'b010;
    assign bus.Hburst    = hburst_q;
    assign bus.Hprot     = 4'b0011;
    assign bus.Hmastlock = 1'b0;
    assign bus.Htrans    = htrans_q;
    assign bus.Hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: the bench plays the slave and the
// upstream data source, logs bus activity and compares it to hand-built expectations.
module tb_ahb_burst_master;

  localparam logic [31:0] RD_KEY = 32'hC0DE_0000;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_burst = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wdata;
  logic        wdata_pop;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  ahb_burst_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .Hclk        (Hclk),
    .Hreset      (Hreset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_burst   (cmd_burst),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_pop   (wdata_pop),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .dbg_state   (dbg_state),
    .bus         (bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 Hclk = ~Hclk;

  // ---------------- slave model and source ----------------
  int          cyc = 0;
  int          pop_cnt = 0;
  int          pop_base = 0;
  logic [31:0] wbase = '0;
  logic        dp_act = 1'b0;
  logic [31:0] dp_addr = '0;

  assign wdata = wbase + 32'(pop_cnt - pop_base);
  assign bus.Hrdata = dp_addr ^ RD_KEY;

  initial begin
    bus.Hready = 1'b1;
    bus.Hresp  = 1'b0;
  end

  always @(posedge Hclk) begin
    cyc <= cyc + 1;
    if (wdata_pop) pop_cnt <= pop_cnt + 1;
    if (Hreset) begin
      dp_act  <= 1'b0;
      dp_addr <= '0;
    end else if (bus.Hready) begin
      dp_act <= bus.Htrans[1];
      if (bus.Htrans[1]) dp_addr <= bus.Haddr;
    end
  end

  // ---------------- monitor logs ----------------
  logic [31:0] addr_log[$];
  logic [31:0] trans_log[$];
  logic [31:0] wd_log[$];
  logic [31:0] rd_log[$];
  int          done_n = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;

  always @(negedge Hclk) begin
    if (!Hreset) begin
      if (bus.Htrans[1] && bus.Hready) begin
        addr_log.push_back(bus.Haddr);
        trans_log.push_back({30'd0, bus.Htrans});
      end
      if (dp_act && bus.Hready && !bus.Hresp && bus.Hwrite) wd_log.push_back(bus.Hwdata);
      if (rdata_valid) rd_log.push_back(rdata);
      if (done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc;
        done_err <= err;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_t[$];
  logic [31:0] exp_d[$];
  int          acc_cyc = 0;
  int          done_base = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] got[$], input logic [31:0] want[$]);
    check({tag, "_len"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], want[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    addr_log.delete();
    trans_log.delete();
    wd_log.delete();
    rd_log.delete();
    exp_q.delete();
    exp_t.delete();
    exp_d.delete();
    pop_base = pop_cnt;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [2:0] b, input logic [3:0] l);
    bit got_it;
    got_it = 1'b0;
    @(posedge Hclk); #1;
    clear_logs();
    cmd_write = w;
    cmd_addr  = a;
    cmd_burst = b;
    cmd_len   = l;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Hclk); #1;
      if (cmd_ready) begin
        got_it    = 1'b1;
        acc_cyc   = cyc;
        done_base = done_n;
        break;
      end
    end
    check("cmd_accept", 32'(got_it), 32'd1);
    @(posedge Hclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Htrans[1] && bus.Haddr == a) begin
        seen = 1'b1;
        break;
      end
      @(negedge Hclk); #1;
    end
    check($sformatf("wait_addr_%h", a), 32'(seen), 32'd1);
  endtask

  task automatic wait_done(output int lat, output logic e);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_n != done_base) begin
        seen = 1'b1;
        break;
      end
      @(negedge Hclk); #1;
    end
    check("done_seen", 32'(seen), 32'd1);
    lat = done_cyc - acc_cyc;
    e   = done_err;
  endtask

  // ---------------- test sequence ----------------
  int   lat;
  logic e;

  initial begin
    // reset: command pending must not be accepted or popped
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    repeat (3) @(posedge Hclk);
    @(negedge Hclk); #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_wdata_pop", 32'(wdata_pop), 32'd0);
    check("rst_htrans", 32'(bus.Htrans), 32'd0);
    check("rst_hsel", 32'(bus.Hsel), 32'd0);
    check("rst_haddr", bus.Haddr, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("hsize", 32'(bus.Hsize), 32'd2);
    check("hprot", 32'(bus.Hprot), 32'd3);
    check("hmastlock", 32'(bus.Hmastlock), 32'd0);
    cmd_valid = 1'b0;
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(negedge Hclk); #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // SINGLE write at 0x10
    wbase = 32'hA5A5_A5A5;
    send_cmd(1'b1, 32'h10, 3'b000, 4'd0);
    exp_q = '{32'h10};
    exp_t = '{32'h2};
    exp_d = '{32'hA5A5_A5A5};
    wait_done(lat, e);
    check("single_latency", 32'(lat), 32'd3);
    check("single_err", 32'(e), 32'd0);
    check_q("single_addr", addr_log, exp_q);
    check_q("single_trans", trans_log, exp_t);
    check_q("single_hwdata", wd_log, exp_d);
    check("single_hburst", 32'(bus.Hburst), 32'd0);
    check("single_pops", 32'(pop_cnt - pop_base), 32'd1);
    @(negedge Hclk); #1;
    check("single_done_pulse", 32'(done), 32'd0);
    check("single_ready_after", 32'(cmd_ready), 32'd1);

    // INCR4 read at 0x40, two wait states on beat 2
    send_cmd(1'b0, 32'h40, 3'b011, 4'd0);
    check("incr4_hburst", 32'(bus.Hburst), 32'd3);
    wait_addr(32'h44);
    @(posedge Hclk); #1;
    bus.Hready = 1'b0;
    @(negedge Hclk); #1;
    check("stall0_haddr", bus.Haddr, 32'h48);
    check("stall0_htrans", 32'(bus.Htrans), 32'd3);
    @(posedge Hclk); #1;
    @(negedge Hclk); #1;
    check("stall1_haddr", bus.Haddr, 32'h48);
    check("stall1_htrans", 32'(bus.Htrans), 32'd3);
    check("stall1_hwrite", 32'(bus.Hwrite), 32'd0);
    check("stall1_hsel", 32'(bus.Hsel), 32'd1);
    check("stall1_no_rvalid", 32'(rdata_valid), 32'd0);
    @(posedge Hclk); #1;
    bus.Hready = 1'b1;
    exp_q = '{32'h40, 32'h44, 32'h48, 32'h4C};
    exp_t = '{32'h2, 32'h3, 32'h3, 32'h3};
    exp_d = '{32'h40 ^ RD_KEY, 32'h44 ^ RD_KEY, 32'h48 ^ RD_KEY, 32'h4C ^ RD_KEY};
    wait_done(lat, e);
    check("incr4_latency", 32'(lat), 32'd8);
    check("incr4_err", 32'(e), 32'd0);
    check_q("incr4_addr", addr_log, exp_q);
    check_q("incr4_trans", trans_log, exp_t);
    check_q("incr4_rdata", rd_log, exp_d);

    // WRAP4 write at 0x38
    wbase = 32'h1234_0000;
    send_cmd(1'b1, 32'h38, 3'b010, 4'd0);
    exp_q = '{32'h38, 32'h3C, 32'h30, 32'h34};
    exp_d = '{32'h1234_0000, 32'h1234_0001, 32'h1234_0002, 32'h1234_0003};
    wait_done(lat, e);
    repeat (3) @(negedge Hclk);
    #1;
    check("wrap4_latency", 32'(lat), 32'd6);
    check_q("wrap4_addr", addr_log, exp_q);
    check_q("wrap4_hwdata", wd_log, exp_d);
    check("wrap4_pops", 32'(pop_cnt - pop_base), 32'd4);
    check("wrap4_done_count", 32'(done_n - done_base), 32'd1);

    // INCR, 6 beats, rolling over the top of the address space
    send_cmd(1'b0, 32'hFFFF_FFF8, 3'b001, 4'd5);
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    exp_d = '{32'hFFFF_FFF8 ^ RD_KEY, 32'hFFFF_FFFC ^ RD_KEY, RD_KEY,
              32'h4 ^ RD_KEY, 32'h8 ^ RD_KEY, 32'hC ^ RD_KEY};
    wait_done(lat, e);
    check("incr6_latency", 32'(lat), 32'd8);
    check_q("incr6_addr", addr_log, exp_q);
    check_q("incr6_rdata", rd_log, exp_d);

    // INCR8 write, error response during beat 3 data phase
    wbase = 32'h5000_0000;
    send_cmd(1'b1, 32'h100, 3'b101, 4'd0);
    wait_addr(32'h10C);
    @(posedge Hclk); #1;
    bus.Hresp = 1'b1;
    @(negedge Hclk); #1;
    check("err_beat4_addr", bus.Haddr, 32'h110);
    @(posedge Hclk); #1;
    bus.Hresp = 1'b0;
    @(negedge Hclk); #1;
    check("err_htrans", 32'(bus.Htrans), 32'd0);
    check("err_hsel", 32'(bus.Hsel), 32'd0);
    check("err_done", 32'(done), 32'd1);
    check("err_flag", 32'(err), 32'd1);
    wait_done(lat, e);
    repeat (4) @(negedge Hclk);
    #1;
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    check("err_done_err", 32'(e), 32'd1);
    check_q("err_addr", addr_log, exp_q);
    check("err_pops", 32'(pop_cnt - pop_base), 32'd5);
    check("err_done_count", 32'(done_n - done_base), 32'd1);
    check("err_ready_after", 32'(cmd_ready), 32'd1);

    // reset in the middle of a WRAP16 read
    send_cmd(1'b0, 32'h84, 3'b110, 4'd0);
    wait_addr(32'h8C);
    @(posedge Hclk); #1;
    Hreset = 1'b1;
    @(negedge Hclk); #1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(negedge Hclk); #1;
    check("midrst_htrans", 32'(bus.Htrans), 32'd0);
    check("midrst_hsel", 32'(bus.Hsel), 32'd0);
    check("midrst_haddr", bus.Haddr, 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge Hclk);
    #1;
    check("midrst_no_done", 32'(done_n - done_base), 32'd0);

    // SINGLE read after reset, low address bits ignored
    send_cmd(1'b0, 32'h22, 3'b000, 4'd0);
    exp_q = '{32'h20};
    exp_d = '{32'h20 ^ RD_KEY};
    wait_done(lat, e);
    check("post_single_latency", 32'(lat), 32'd3);
    check("post_single_err", 32'(e), 32'd0);
    check_q("post_single_addr", addr_log, exp_q);
    check_q("post_single_rdata", rd_log, exp_d);

    repeat (2) @(posedge Hclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
